// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enables, bubbles/flushes, EX forwarding, DMEM wait/timeout and perf counters
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read2,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic             mem_req,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             ex_br_taken,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   typedef enum logic {RUN, DMEM_WAIT} state_t;
   localparam logic [15:0] TO    = 16'(MEM_TIMEOUT);
   localparam logic [15:0] TO_M1 = 16'(MEM_TIMEOUT - 1);
   state_t      state;
   logic [15:0] wait_cnt;
   logic        dmem_stall, load_use, stall_ev, flush_ev;
   logic [6:0]  ctl;
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic m_we, input logic [4:0] m_rd,
                                          input logic w_we, input logic [4:0] w_rd);
      return (m_we && m_rd != 5'd0 && m_rd == rs) ? 2'b01 :
             (w_we && w_rd != 5'd0 && w_rd == rs) ? 2'b10 : 2'b00;
   endfunction
   assign dmem_stall = mem_req & ~dmem_ready;
   assign load_use   = ex_mem_read2 & ex_reg_write & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign stall_ev   = dmem_stall | (~ex_br_taken & (load_use | ~imem_ready));
   assign flush_ev   = ~dmem_stall & ex_br_taken;
   // priority-ordered stage control {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
   always_comb begin
      ctl = !rst_n      ? 7'b0000000 :
            dmem_stall  ? 7'b0000000 :
            ex_br_taken ? 7'b1111111 :
            load_use    ? 7'b0011101 :
            !imem_ready ? 7'b0111110 : 7'b1111100;
   end
   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} = ctl;
   assign fwd_a = rst_n ? fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd) : 2'b00;
   assign fwd_b = rst_n ? fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd) : 2'b00;
   // data-memory wait FSM; the wait count stops at the timeout so it never wraps, and the error is sticky
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else if (state == RUN) begin
         wait_cnt <= '0;
         if (dmem_stall) state <= DMEM_WAIT;
      end else begin
         if (wait_cnt != TO) wait_cnt <= wait_cnt + 16'd1;
         if (wait_cnt == TO_M1) mem_err <= 1'b1;
         if (dmem_ready) state <= RUN;
      end
   end
   // saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (stall_ev && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_ev && !(&flush_events)) flush_events <= flush_events + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus checked against a behavioural hazard model
module tb_pipeline_hazard_ctrl;
   localparam int CW  = 4;
   localparam int TO  = 4;
   localparam int MAX = (1 << CW) - 1;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read2, mem_reg_write, mem_req;
   logic          wb_reg_write, ex_br_taken, imem_ready, dmem_ready;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_err;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cycles, flush_events;
   int            n_chk = 0, n_fail = 0;
   bit            m_wait, m_err;
   int            m_cnt, m_stall, m_flush, s_before;
   logic [6:0]    tab [1:5] = '{7'b0000000, 7'b1111111, 7'b0011101, 7'b0111110, 7'b1111100};

   pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read2(ex_mem_read2), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_req(mem_req), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .ex_br_taken(ex_br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .pc_en(pc_en),
      .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick_case();
      bit lu;
      lu = ex_mem_read2 && ex_reg_write && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (mem_req && !dmem_ready) return 1;
      if (ex_br_taken) return 2;
      if (lu) return 3;
      if (!imem_ready) return 4;
      return 5;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
      if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   task automatic check_all(input string tag);
      logic [6:0] ctl;
      ctl = rst_n ? tab[pick_case()] : 7'b0;
      chk({tag, "_ctl"}, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}, ctl);
      chk({tag, "_fwd_a"}, fwd_a, rst_n ? exp_fwd(ex_rs1) : 2'b00);
      chk({tag, "_fwd_b"}, fwd_b, rst_n ? exp_fwd(ex_rs2) : 2'b00);
      chk({tag, "_mem_err"}, mem_err, m_err);
      chk({tag, "_stall_cnt"}, stall_cycles, m_stall);
      chk({tag, "_flush_cnt"}, flush_events, m_flush);
   endtask

   task automatic model_clock();
      int c;
      c = pick_case();
      if (m_wait) begin
         m_cnt = (m_cnt < TO) ? m_cnt + 1 : TO;
         if (m_cnt >= TO) m_err = 1;
         if (dmem_ready) m_wait = 0;
      end else begin
         m_cnt = 0;
         if (mem_req && !dmem_ready) m_wait = 1;
      end
      if (c == 1 || c == 3 || c == 4) m_stall = (m_stall < MAX) ? m_stall + 1 : MAX;
      if (c == 2) m_flush = (m_flush < MAX) ? m_flush + 1 : MAX;
   endtask

   // called just after a falling edge with inputs already driven
   task automatic step(input string tag);
      #1 check_all(tag);
      model_clock();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      m_wait = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
      #1 check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read2, mem_reg_write, mem_req} = '0;
      {wb_reg_write, ex_br_taken} = '0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
   endtask

   initial begin
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      do_reset("reset");
      // load-use: lw x5 in EX, add x?,x5 in ID
      ex_mem_read2 = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
      step("load_use");
      chk("load_use_stall_is_1", stall_cycles, 1);
      idle(); step("after_lu");
      // forwarding priority
      mem_reg_write = 1; wb_reg_write = 1; mem_rd = 3; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3;
      #1 chk("fwd_mem_a", fwd_a, 2'b01); chk("fwd_mem_b", fwd_b, 2'b01);
      step("fwd_mem");
      mem_rd = 0;
      #1 chk("fwd_wb_a", fwd_a, 2'b10);
      step("fwd_wb");
      wb_rd = 0;
      #1 chk("fwd_none_a", fwd_a, 2'b00);
      step("fwd_none");
      // DMEM wait of 4 cycles
      idle(); mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 4; i++) step("dmem_wait");
      dmem_ready = 1; step("dmem_done");
      idle(); step("dmem_run");
      // redirect together with load-use
      s_before = m_stall;
      ex_br_taken = 1; ex_mem_read2 = 1; ex_reg_write = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
      #1 chk("redir_pc_en", pc_en, 1); chk("redir_flushes", {if_id_flush, id_ex_flush}, 2'b11);
      step("redir_lu");
      chk("redir_flush_cnt", flush_events, 1);
      chk("redir_stall_same", stall_cycles, s_before);
      // timeout: DMEM_READY low 6 cycles
      idle(); mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 6; i++) step("timeout");
      dmem_ready = 1; step("timeout_done");
      idle(); step("timeout_hold");
      chk("timeout_err_sticky", mem_err, 1);
      // counter saturation from a clean start
      do_reset("sat_reset");
      imem_ready = 0;
      for (int i = 0; i < 20; i++) step("sat");
      chk("stall_saturated", stall_cycles, MAX);
      // reset while waiting on data memory
      idle(); mem_req = 1; dmem_ready = 0;
      step("pre_rst_wait"); step("pre_rst_wait2");
      do_reset("rst_mid_wait");
      idle(); step("post_rst");
      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if (i % 60 == 59) do_reset("rand_reset");
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
         wb_rd = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
         ex_reg_write = 1'($urandom); ex_mem_read2 = 1'($urandom);
         mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
         mem_req = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 2) == 0);
         imem_ready = ($urandom_range(0, 3) != 0);
         ex_br_taken = ($urandom_range(0, 7) == 0);
         step("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
